// File: rtl/seg7_reader_pkg.sv
// seg7_reader_pkg
//   Shared definitions for the seven-segment receive path.
//   - SEG_* : segment patterns, bit0 = seg1 .. bit6 = seg7. These are the same
//             values the letter encoder drives, so both ends use one table.
//   - SYM_* : recovered symbol codes, including SYM_UNKNOWN for anything else.
//   - state_e : encodings for the word-tracking FSM.
//   - seg_to_sym() : reverse lookup with the O position rule.
package seg7_reader_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_R     = 7'b1110000;
  localparam logic [6:0] SEG_O     = 7'b0111111;
  localparam logic [6:0] SEG_G     = 7'b1101111;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_L     = 7'b0111000;
  localparam logic [6:0] SEG_I     = 7'b0110000;

  localparam logic [3:0] SYM_BLANK   = 4'd0;
  localparam logic [3:0] SYM_R       = 4'd1;
  localparam logic [3:0] SYM_O_FIRST = 4'd2;
  localparam logic [3:0] SYM_G       = 4'd3;
  localparam logic [3:0] SYM_E       = 4'd4;
  localparam logic [3:0] SYM_L       = 4'd5;
  localparam logic [3:0] SYM_I       = 4'd6;
  localparam logic [3:0] SYM_O_LAST  = 4'd7;
  localparam logic [3:0] SYM_UNKNOWN = 4'd15;

  // Number of letters in "ROGELIO"; also the final seq_pos value.
  localparam logic [2:0] WORD_LEN = 3'd7;

  // ST_DONE holds seq_pos at 7 for exactly one cycle after the last letter,
  // then falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The letter O appears twice in the word; the second one is only expected
  // after six letters have matched, so that is the only place it decodes as 7.
  function automatic logic [3:0] seg_to_sym(input logic [6:0] seg,
                                            input logic [2:0] seq_pos);
    logic [3:0] sym;
    unique case (seg)
      SEG_BLANK: sym = SYM_BLANK;
      SEG_R:     sym = SYM_R;
      SEG_O:     sym = (seq_pos == 3'd6) ? SYM_O_LAST : SYM_O_FIRST;
      SEG_G:     sym = SYM_G;
      SEG_E:     sym = SYM_E;
      SEG_L:     sym = SYM_L;
      SEG_I:     sym = SYM_I;
      default:   sym = SYM_UNKNOWN;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/seg7_reader_stabilizer.sv
// seg7_reader_stabilizer
//   Samples the segment bus and raises a one-cycle accept strobe once a
//   pattern has been seen STABLE_CYCLES times in a row and differs from the
//   last pattern accepted.
// Ports
//   clk, rst_n     : clock, synchronous active-low reset
//   ena            : clock enable; low freezes all state
//   segments_in[7] : raw segment bus
//   sample_o[7]    : registered sample (the pattern being accepted)
//   accept_o       : strobe, valid in the cycle the acceptance edge follows
module seg7_reader_stabilizer #(
  parameter int STABLE_CYCLES = 4,
  parameter int STAB_W        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] segments_in,
  output logic [6:0] sample_o,
  output logic       accept_o
);

  localparam logic [STAB_W-1:0] CNT_MAX = STAB_W'(STABLE_CYCLES - 1);

  logic [6:0]        s_q, s_d;
  logic [6:0]        last_q, last_d;
  logic [STAB_W-1:0] cnt_q, cnt_d;
  logic              run_q, run_d;   // current stable run already accepted
  logic              accept;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    s_d    = s_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    accept = (cnt_q == CNT_MAX) && (s_q != last_q) && !run_q;
    if (ena) begin
      s_d = segments_in;
      if (accept) begin
        last_d = s_q;
        run_d  = 1'b1;
      end
      // A change starts a fresh run; it must override the accept above so a
      // new pattern arriving on the acceptance edge is still eligible.
      if (segments_in != s_q) begin
        cnt_d = '0;
        run_d = 1'b0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the reset is sampled on the clock edge (synchronous), and all
  // state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign sample_o = s_q;
  assign accept_o = accept && ena;

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader
//   Loopback monitor for the seven-segment letter display. Debounces the
//   segment bus, decodes accepted patterns back to symbol codes and tracks
//   the "R-O-G-E-L-I-O" word.
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   ena             : clock enable; low freezes state and masks pulses
//   segments_in[7]  : segment bus, bit0 = seg1 .. bit6 = seg7
//   symbol_valid    : one-cycle pulse per accepted symbol
//   symbol[4]       : last recovered code (holds between pulses)
//   seq_pos[3]      : letters of the word matched so far
//   word_done       : pulse with the seventh matched letter
//   seq_error       : pulse when an out-of-order symbol arrives mid-word
module seg7_reader
  import seg7_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int STAB_W        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] segments_in,
  output logic       symbol_valid,
  output logic [3:0] symbol,
  output logic [2:0] seq_pos,
  output logic       word_done,
  output logic       seq_error
);

  logic [6:0] sample;
  logic       accept;
  logic [3:0] sym;
  logic       sym_match;

  state_e     state_q, state_d;
  logic [2:0] seq_pos_q, seq_pos_d;
  logic [3:0] symbol_q, symbol_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  seg7_reader_stabilizer #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .STAB_W        (STAB_W)
  ) u_stab (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .segments_in (segments_in),
    .sample_o    (sample),
    .accept_o    (accept)
  );

  assign sym       = seg_to_sym(sample, seq_pos_q);
  // In MATCH with k letters seen, the next expected code is k+1.
  assign sym_match = (sym == ({1'b0, seq_pos_q} + 4'd1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      seq_pos_q <= '0;
      symbol_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_pos_q <= seq_pos_d;
      symbol_q  <= symbol_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: the word tracker only moves on an accept, except for
  // the automatic DONE -> IDLE return one cycle after the last letter.
  always_comb begin
    state_d   = state_q;
    seq_pos_d = seq_pos_q;
    if (ena) begin
      if (state_q == ST_DONE) begin
        state_d   = ST_IDLE;
        seq_pos_d = '0;
      end
      if (accept) begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (sym == SYM_R) begin
              state_d   = ST_MATCH;
              seq_pos_d = 3'd1;
            end
          end
          ST_MATCH: begin
            if (sym_match) begin
              seq_pos_d = seq_pos_q + 3'd1;
              if (seq_pos_q + 3'd1 == WORD_LEN) state_d = ST_DONE;
            end else if (sym == SYM_R) begin
              seq_pos_d = 3'd1;     // restart the word
            end else begin
              state_d   = ST_IDLE;
              seq_pos_d = '0;
            end
          end
          default: begin
            state_d   = ST_IDLE;
            seq_pos_d = '0;
          end
        endcase
      end
    end
  end

  // Output logic: pulses are recomputed on every enabled edge and held while
  // the block is frozen (they are masked at the ports meanwhile).
  always_comb begin
    symbol_d = symbol_q;
    valid_d  = valid_q;
    done_d   = done_q;
    err_d    = err_q;
    if (ena) begin
      valid_d = accept;
      done_d  = accept && (state_q == ST_MATCH) && sym_match &&
                (seq_pos_q == WORD_LEN - 3'd1);
      err_d   = accept && (state_q == ST_MATCH) && !sym_match;
      if (accept) symbol_d = sym;
    end
  end

  assign symbol_valid = valid_q && ena;
  assign word_done    = done_q && ena;
  assign seq_error    = err_q && ena;
  assign symbol       = symbol_q;
  assign seq_pos      = seq_pos_q;

endmodule

// File: tb/tb_seg7_reader.sv
module tb_seg7_reader;

  localparam logic [6:0] P_BLANK = 7'b0000000;
  localparam logic [6:0] P_R     = 7'b1110000;
  localparam logic [6:0] P_O     = 7'b0111111;
  localparam logic [6:0] P_G     = 7'b1101111;
  localparam logic [6:0] P_E     = 7'b1111001;
  localparam logic [6:0] P_L     = 7'b0111000;
  localparam logic [6:0] P_I     = 7'b0110000;
  localparam logic [6:0] P_BAD   = 7'b1010101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [6:0] segments_in;
  logic       symbol_valid;
  logic [3:0] symbol;
  logic [2:0] seq_pos;
  logic       word_done;
  logic       seq_error;

  typedef struct {
    logic [3:0] sym;
    logic [2:0] pos;
    logic       wd;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int last_valid_cyc = 0;

  seg7_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .segments_in  (segments_in),
    .symbol_valid (symbol_valid),
    .symbol       (symbol),
    .seq_pos      (seq_pos),
    .word_done    (word_done),
    .seq_error    (seq_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] sym, input logic [2:0] pos,
                      input logic wd, input logic err);
    exp_t e;
    e.sym = sym;
    e.pos = pos;
    e.wd  = wd;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Drive a pattern and hold it for n clock edges; returns just after an edge.
  task automatic hold(input logic [6:0] p, input int n);
    segments_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every symbol_valid pulse pops one expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("stray_pulse", 32'((word_done | seq_error) & ~symbol_valid), 32'd0);
      if (symbol_valid === 1'b1) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("symbol",    32'(symbol),    32'(e.sym));
          chk("seq_pos",   32'(seq_pos),   32'(e.pos));
          chk("word_done", 32'(word_done), 32'(e.wd));
          chk("seq_error", 32'(seq_error), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] word [7];
    int t0;
    int v0;

    word[0] = P_R; word[1] = P_O; word[2] = P_G; word[3] = P_E;
    word[4] = P_L; word[5] = P_I; word[6] = P_O;

    // Reset state
    rst_n = 1'b0;
    ena = 1'b1;
    segments_in = P_BLANK;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  32'(symbol_valid), 32'd0);
    chk("rst_symbol", 32'(symbol),       32'd0);
    chk("rst_pos",    32'(seq_pos),      32'd0);
    chk("rst_done",   32'(word_done),    32'd0);
    chk("rst_err",    32'(seq_error),    32'd0);
    rst_n = 1'b1;

    // 1: R held 6 cycles, one pulse after 5 cycles
    push(4'd1, 3'd1, 1'b0, 1'b0);
    t0 = cyc;
    hold(P_R, 6);
    chk("t1_count",   32'(n_valid), 32'd1);
    chk("t1_latency", 32'(last_valid_cyc - t0), 32'd5);

    // 3: 3-cycle glitch while R stable -> nothing
    v0 = n_valid;
    hold(P_E, 3);
    hold(P_R, 8);
    chk("t3_count",  32'(n_valid), 32'(v0));
    chk("t3_pos",    32'(seq_pos), 32'd1);
    chk("t3_symbol", 32'(symbol),  32'd1);

    // Blank mid-word aborts back to IDLE with an error
    push(4'd0, 3'd0, 1'b0, 1'b1);
    hold(P_BLANK, 8);

    // 2: full word
    for (int i = 0; i < 7; i++) begin
      push(4'(i + 1), 3'(i + 1), (i == 6), 1'b0);
      hold(word[i], 8);
    end
    chk("t2_pos_back", 32'(seq_pos), 32'd0);
    chk("t2_symbol",   32'(symbol),  32'd7);

    // 4: R, O, then L instead of G -> error; R restarts
    push(4'd1, 3'd1, 1'b0, 1'b0);
    hold(P_R, 8);
    push(4'd2, 3'd2, 1'b0, 1'b0);
    hold(P_O, 8);
    push(4'd5, 3'd0, 1'b0, 1'b1);
    hold(P_L, 8);
    chk("t4_pos_err", 32'(seq_pos), 32'd0);
    push(4'd1, 3'd1, 1'b0, 1'b0);
    hold(P_R, 8);
    chk("t4_pos_restart", 32'(seq_pos), 32'd1);

    // 5: unknown pattern mid-word
    push(4'd2, 3'd2, 1'b0, 1'b0);
    hold(P_O, 8);
    push(4'd15, 3'd0, 1'b0, 1'b1);
    hold(P_BAD, 8);
    chk("t5_pos", 32'(seq_pos), 32'd0);

    // 6: reset after E accepted
    push(4'd1, 3'd1, 1'b0, 1'b0);
    hold(P_R, 8);
    push(4'd2, 3'd2, 1'b0, 1'b0);
    hold(P_O, 8);
    push(4'd3, 3'd3, 1'b0, 1'b0);
    hold(P_G, 8);
    push(4'd4, 3'd4, 1'b0, 1'b0);
    hold(P_E, 8);
    segments_in = P_BLANK;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_valid",  32'(symbol_valid), 32'd0);
    chk("t6_symbol", 32'(symbol),       32'd0);
    chk("t6_pos",    32'(seq_pos),      32'd0);
    chk("t6_done",   32'(word_done),    32'd0);
    chk("t6_err",    32'(seq_error),    32'd0);
    rst_n = 1'b1;
    v0 = n_valid;
    hold(P_BLANK, 10);
    chk("t6_blank_ignored", 32'(n_valid), 32'(v0));

    // ena low for 10 cycles during stabilisation delays acceptance by 10
    push(4'd1, 3'd1, 1'b0, 1'b0);
    t0 = cyc;
    v0 = n_valid;
    hold(P_R, 2);
    ena = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("ena_frozen_valid", 32'(symbol_valid), 32'd0);
    chk("ena_frozen_pos",   32'(seq_pos),      32'd0);
    ena = 1'b1;
    for (int k = 0; k < 30 && n_valid == v0; k++) @(posedge clk);
    #1;
    chk("ena_accept_seen", 32'(n_valid), 32'(v0 + 1));
    chk("ena_latency", 32'(last_valid_cyc - t0), 32'd15);
    hold(P_R, 4);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
